// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop process WIDTH-bit
// operands LSB first, stream each sum bit, then publish the parallel result with flags.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             sum_bit_o,
  output logic             sum_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q,   state_d;
  logic [WIDTH-1:0]  a_q,       a_d;
  logic [WIDTH-1:0]  b_q,       b_d;
  logic [WIDTH-1:0]  sum_q,     sum_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic              c_q,       c_d;
  logic              sum_bit_q, sum_bit_d;
  logic              valid_q,   valid_d;
  logic [WIDTH-1:0]  result_q,  result_d;
  logic              co_q,      co_d;
  logic              ov_q,      ov_d;
  logic              done_q,    done_d;

  logic s, c_next;

  // One full-adder cell; the carry flip-flop holds the carry into the current bit.
  assign s      = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    sum_bit_d = sum_bit_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    co_d      = co_q;
    ov_d      = ov_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          c_d     = sub_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d       = a_q >> 1;
        b_d       = b_q >> 1;
        c_d       = c_next;
        sum_d     = {s, sum_q[WIDTH-1:1]};
        sum_bit_d = s;
        valid_d   = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // On the MSB step c_q is the carry into the MSB, so overflow = c_in ^ c_out.
          result_d = {s, sum_q[WIDTH-1:1]};
          co_d     = c_next;
          ov_d     = c_q ^ c_next;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      sum_bit_q <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      co_q      <= 1'b0;
      ov_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      sum_bit_q <= sum_bit_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      co_q      <= co_d;
      ov_q      <= ov_d;
      done_q    <= done_d;
    end
  end

  assign busy_o      = (state_q == RUN);
  assign sum_bit_o   = sum_bit_q;
  assign sum_valid_o = valid_q;
  assign result_o    = result_q;
  assign carry_out_o = co_q;
  assign overflow_o  = ov_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: WIDTH=8 and WIDTH=4 instances checked every cycle against an
// arithmetic model, plus directed operations with hand-computed results.
module tb_serial_addsub;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start_v, sub_v;
  logic [31:0] a_v [2];
  logic [31:0] b_v [2];
  logic [1:0]  busy_v, bit_v, valid_v, co_v, ov_v, done_v;
  logic [7:0]  res0;
  logic [3:0]  res1;
  logic [31:0] res_v [2];
  int          w_of [2] = '{8, 4};

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .sub_i(sub_v[0]),
    .a_i(a_v[0][7:0]), .b_i(b_v[0][7:0]), .busy_o(busy_v[0]), .sum_bit_o(bit_v[0]),
    .sum_valid_o(valid_v[0]), .result_o(res0), .carry_out_o(co_v[0]),
    .overflow_o(ov_v[0]), .done_o(done_v[0]));

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .sub_i(sub_v[1]),
    .a_i(a_v[1][3:0]), .b_i(b_v[1][3:0]), .busy_o(busy_v[1]), .sum_bit_o(bit_v[1]),
    .sum_valid_o(valid_v[1]), .result_o(res1), .carry_out_o(co_v[1]),
    .overflow_o(ov_v[1]), .done_o(done_v[1]));

  assign res_v[0] = {24'b0, res0};
  assign res_v[1] = {28'b0, res1};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain arithmetic on unsigned and signed interpretations of the operands.
  function automatic op_t golden(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    op_t    r;
    longint full, half, ua, ub, sa, sb, sr;
    full = longint'(1) << w;
    half = full >> 1;
    ua   = longint'(a) & (full - 1);
    ub   = longint'(b) & (full - 1);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    if (s) begin
      r.res = 32'((ua - ub) & (full - 1));
      r.co  = (ua >= ub);
      sr    = sa - sb;
    end else begin
      r.res = 32'((ua + ub) & (full - 1));
      r.co  = ((ua + ub) >= full);
      sr    = sa + sb;
    end
    r.ov = (sr >= half) || (sr < -half);
    return r;
  endfunction

  // Model: an accepted operation produces bit k of its result after edge k+1,
  // and result/flags/done after edge WIDTH.
  logic        m_run [2];
  int          m_k   [2];
  op_t         m_op  [2];
  logic        e_bit [2], e_valid [2], e_done [2], e_co [2], e_ov [2];
  logic [31:0] e_res [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] <= 1'b0; m_k[i] <= 0; m_op[i] <= '0;
        e_bit[i] <= 1'b0; e_valid[i] <= 1'b0; e_done[i] <= 1'b0;
        e_co[i] <= 1'b0; e_ov[i] <= 1'b0; e_res[i] <= '0;
      end else if (m_run[i]) begin
        e_bit[i]   <= m_op[i].res[m_k[i]];
        e_valid[i] <= 1'b1;
        if (m_k[i] == w_of[i] - 1) begin
          m_run[i]  <= 1'b0;
          e_done[i] <= 1'b1;
          e_res[i]  <= m_op[i].res;
          e_co[i]   <= m_op[i].co;
          e_ov[i]   <= m_op[i].ov;
        end else begin
          m_k[i]    <= m_k[i] + 1;
          e_done[i] <= 1'b0;
        end
      end else begin
        e_valid[i] <= 1'b0;
        e_done[i]  <= 1'b0;
        if (start_v[i]) begin
          m_run[i] <= 1'b1;
          m_k[i]   <= 0;
          m_op[i]  <= golden(w_of[i], a_v[i], b_v[i], sub_v[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("w%0d_busy", w_of[i]), 32'(busy_v[i]), 32'(m_run[i]));
      check($sformatf("w%0d_sum_valid", w_of[i]), 32'(valid_v[i]), 32'(e_valid[i]));
      check($sformatf("w%0d_done", w_of[i]), 32'(done_v[i]), 32'(e_done[i]));
      check($sformatf("w%0d_result", w_of[i]), res_v[i], e_res[i]);
      check($sformatf("w%0d_carry_out", w_of[i]), 32'(co_v[i]), 32'(e_co[i]));
      check($sformatf("w%0d_overflow", w_of[i]), 32'(ov_v[i]), 32'(e_ov[i]));
      if (e_valid[i])
        check($sformatf("w%0d_sum_bit", w_of[i]), 32'(bit_v[i]), 32'(e_bit[i]));
    end
  end

  // Starts an operation at the current negedge and waits (bounded) for done.
  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] x_res, input logic x_co,
                       input logic x_ov, input string nm, input bit mid_pulse);
    int          lat;
    int          nb;
    logic [31:0] stream;
    start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; sub_v[i] = s;
    @(posedge clk);
    @(negedge clk);
    start_v[i] = 1'b0;
    lat = 0; nb = 0; stream = '0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid_v[i] && nb < 32) begin
        stream[nb] = bit_v[i];
        nb++;
      end
      if (mid_pulse && lat == 3) begin
        start_v[i] = 1'b1; a_v[i] = 32'h55; b_v[i] = 32'h22; sub_v[i] = 1'b1;
      end else if (mid_pulse && lat == 4) begin
        start_v[i] = 1'b0;
      end
    end while (!done_v[i] && lat < 40);
    check({nm, "_latency"}, lat, w_of[i]);
    check({nm, "_result"}, res_v[i], x_res);
    check({nm, "_carry_out"}, 32'(co_v[i]), 32'(x_co));
    check({nm, "_overflow"}, 32'(ov_v[i]), 32'(x_ov));
    check({nm, "_stream"}, stream, x_res);
    check({nm, "_nbits"}, nb, w_of[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    start_v = '0; sub_v = '0;
    for (int i = 0; i < 2; i++) begin a_v[i] = '0; b_v[i] = '0; end
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_valid", 32'(valid_v), 32'h0);
    check("rst_done", 32'(done_v), 32'h0);
    check("rst_sum_bit", 32'(bit_v), 32'h0);
    check("rst_result8", res_v[0], 32'h0);
    check("rst_flags", {28'b0, co_v, ov_v}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x10 streamed LSB first is 0,0,0,0,1,0,0,0.
    do_op(0, 32'h0B, 32'h05, 1'b0, 32'h10, 1'b0, 1'b0, "add_0b_05", 1'b0);
    do_op(0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, "add_ff_01", 1'b0);
    do_op(0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, "add_7f_01", 1'b0);
    do_op(0, 32'h05, 32'h0B, 1'b1, 32'hFA, 1'b0, 1'b0, "sub_05_0b", 1'b0);
    do_op(0, 32'h21, 32'h12, 1'b0, 32'h33, 1'b0, 1'b0, "ignore_mid", 1'b1);
    @(negedge clk);
    check("ignore_mid_idle", 32'(busy_v[0]), 32'h0);
    do_op(0, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0, "b2b_first", 1'b0);
    do_op(0, 32'h03, 32'h04, 1'b0, 32'h07, 1'b0, 1'b0, "b2b_second", 1'b0);
    do_op(0, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, "sub_80_01", 1'b0);

    // Reset four cycles into an add: outputs clear without waiting for a clock edge.
    start_v[0] = 1'b1; a_v[0] = 32'h0B; b_v[0] = 32'h05; sub_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy_v[0]), 32'h0);
    check("async_rst_valid", 32'(valid_v[0]), 32'h0);
    check("async_rst_result", res_v[0], 32'h0);
    check("async_rst_flags", {29'b0, bit_v[0], co_v[0], ov_v[0]}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("async_rst_no_done", 32'(done_v[0]), 32'h0);
      if (k == 2) rst_n = 1'b1;
    end
    do_op(0, 32'h01, 32'h01, 1'b0, 32'h02, 1'b0, 1'b0, "post_rst_01_01", 1'b0);

    do_op(1, 32'h0B, 32'h05, 1'b0, 32'h0, 1'b1, 1'b0, "w4_add_b_5", 1'b0);
    do_op(1, 32'h3, 32'h5, 1'b1, 32'hE, 1'b0, 1'b0, "w4_sub_3_5", 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
